// File: rtl/edge_magnitude.sv
// Sobel gradient magnitude stage: |gx| + |gy| saturated to 8 bits, edge flag
// against THRESH, and a saturating count of delivered edge pixels.
module edge_magnitude #(
    parameter int THRESH = 128,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       gx_r,
    input  logic [9:0]       gx_l,
    input  logic [9:0]       gy_b,
    input  logic [9:0]       gy_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       mag_out,
    output logic             edge_out,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int              DATA_W    = 10;
    localparam logic [7:0]      THRESH_U8 = THRESH[7:0];
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W:0] d);
        logic signed [DATA_W:0] m;
        m = d[DATA_W] ? -d : d;
        return m[DATA_W-1:0];
    endfunction

    function automatic logic [7:0] sat_u8(input logic [DATA_W:0] s);
        return (|s[DATA_W:8]) ? 8'hFF : s[7:0];
    endfunction

    logic                     adv;
    logic                     vld_p1, vld_p2, vld_p3;
    logic signed [DATA_W:0]   dx_p1, dy_p1;
    logic [DATA_W-1:0]        ax_p2, ay_p2;
    logic [7:0]               mag_p3;
    logic                     edge_p3;
    logic [DATA_W:0]          sum_p2;
    logic [7:0]               mag_nxt;

    // Stall-all pipeline: every stage moves together or holds together.
    assign adv      = !vld_p3 || out_ready;
    assign in_ready = adv;

    assign sum_p2  = {1'b0, ax_p2} + {1'b0, ay_p2};
    assign mag_nxt = sat_u8(sum_p2);

    // S1: signed gradients
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            dx_p1  <= '0;
            dy_p1  <= '0;
        end else if (adv) begin
            vld_p1 <= in_valid;
            dx_p1  <= $signed({1'b0, gx_r}) - $signed({1'b0, gx_l});
            dy_p1  <= $signed({1'b0, gy_b}) - $signed({1'b0, gy_t});
        end
    end

    // S2: absolute values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2 <= 1'b0;
            ax_p2  <= '0;
            ay_p2  <= '0;
        end else if (adv) begin
            vld_p2 <= vld_p1;
            ax_p2  <= abs_val(dx_p1);
            ay_p2  <= abs_val(dy_p1);
        end
    end

    // S3: saturated magnitude and edge flag, drives the outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p3  <= 1'b0;
            mag_p3  <= '0;
            edge_p3 <= 1'b0;
        end else if (adv) begin
            vld_p3  <= vld_p2;
            mag_p3  <= mag_nxt;
            edge_p3 <= (mag_nxt >= THRESH_U8);
        end
    end

    assign out_valid = vld_p3;
    assign mag_out   = mag_p3;
    assign edge_out  = edge_p3;

    // Edge counter counts delivered pixels only; clear has priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
        end else if (cnt_clr) begin
            edge_cnt <= '0;
        end else if (vld_p3 && out_ready && edge_p3 && (edge_cnt != CNT_MAX)) begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

endmodule
